pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with memory-wait watchdog for the 5-stage MIPS core.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] register_d_e,
  input  logic       mem_rd_en_e,
  input  logic [4:0] register_d_m,
  input  logic       reg_write_m,
  input  logic       mem_rd_en_m,
  input  logic       mem_wr_en_m,
  input  logic       mem_ready,
  input  logic [4:0] register_d_w,
  input  logic       reg_write_w,
  input  logic       branch_taken_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       stall_e,
  output logic       stall_m,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       mem_fault,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  if ((MEM_TIMEOUT < 2) || ((2 ** TO_W) <= MEM_TIMEOUT) || (CNT_W < 1)) begin : g_param_check
    $error("pipeline_hazard_ctrl: invalid MEM_TIMEOUT/TO_W/CNT_W");
  end

  state_t          state, state_nxt, eff_state;
  logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            fault_nxt;
  logic            mem_req, load_use, run_rules, hold_all;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == src))      fwd_sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == src)) fwd_sel = 2'b01;
    else                                              fwd_sel = 2'b00;
  endfunction

  always_comb begin
    forward_a_e = fwd_sel(rs_e, register_d_m, reg_write_m, register_d_w, reg_write_w);
    forward_b_e = fwd_sel(rt_e, register_d_m, reg_write_m, register_d_w, reg_write_w);
  end

  assign mem_req  = mem_rd_en_m | mem_wr_en_m;
  assign load_use = mem_rd_en_e && (register_d_e != 5'd0) &&
                    ((register_d_e == rs_d) || (register_d_e == rt_d));
  assign ctrl_state = state;

  // In the reset cycle the outputs follow the RUN rules regardless of the held state.
  always_comb begin
    eff_state    = reset ? RUN : state;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    fault_nxt    = mem_fault;
    run_rules    = 1'b0;
    hold_all     = 1'b0;
    case (eff_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          hold_all     = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = TO_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          run_rules    = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          hold_all = 1'b1;
          if (wait_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + TO_W'(1);
          end
        end
      end
      default: begin
        hold_all  = 1'b1;
        state_nxt = FAULT;
      end
    endcase
  end

  // Branch redirect outranks the load-use bubble; both only apply when the pipe is moving.
  always_comb begin
    stall_f = hold_all;
    stall_d = hold_all;
    stall_e = hold_all;
    stall_m = hold_all;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (run_rules) begin
      if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_fault <= fault_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic bubble_evt, flush_evt;
  assign bubble_evt = run_rules && !branch_taken_e && load_use;
  assign flush_evt  = run_rules && branch_taken_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_m && (stall_cycles != '1))    stall_cycles <= stall_cycles + CNT_W'(1);
      if (bubble_evt && (bubble_count != '1)) bubble_count <= bubble_count + CNT_W'(1);
      if (flush_evt && (flush_count != '1))   flush_count  <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, rd_e;
    logic       ld_e;
    logic [4:0] rd_m;
    logic       rw_m, ld_m, st_m, rdy;
    logic [4:0] rd_w;
    logic       rw_w, br;
  } in_t;

  // stl = {stall_f, stall_d, stall_e, stall_m}, fl = {flush_d, flush_e}
  typedef struct packed {
    logic [3:0] stl;
    logic [1:0] fl;
    logic [1:0] fa, fb;
    logic [1:0] st;
    logic       flt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, register_d_e, register_d_m, register_d_w;
  logic mem_rd_en_e, reg_write_m, mem_rd_en_m, mem_wr_en_m, mem_ready, reg_write_w, branch_taken_e;
  logic stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, mem_fault;
  logic [1:0] forward_a_e, forward_b_e, ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, bubble_count, flush_count;
`endif

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .register_d_e(register_d_e), .mem_rd_en_e(mem_rd_en_e),
    .register_d_m(register_d_m), .reg_write_m(reg_write_m),
    .mem_rd_en_m(mem_rd_en_m), .mem_wr_en_m(mem_wr_en_m), .mem_ready(mem_ready),
    .register_d_w(register_d_w), .reg_write_w(reg_write_w),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_e(stall_e), .stall_m(stall_m),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_fault(mem_fault), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  function automatic exp_t ex(input logic [3:0] stl, input logic [1:0] fl, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [1:0] st, input logic flt);
    exp_t e;
    e.stl = stl; e.fl = fl; e.fa = fa; e.fb = fb; e.st = st; e.flt = flt;
    return e;
  endfunction

  task automatic drive(input in_t s);
    rs_d = s.rs_d; rt_d = s.rt_d; rs_e = s.rs_e; rt_e = s.rt_e;
    register_d_e = s.rd_e; mem_rd_en_e = s.ld_e;
    register_d_m = s.rd_m; reg_write_m = s.rw_m; mem_rd_en_m = s.ld_m; mem_wr_en_m = s.st_m;
    mem_ready = s.rdy; register_d_w = s.rd_w; reg_write_w = s.rw_w; branch_taken_e = s.br;
  endtask

  task automatic applyStimulus(input in_t s, input exp_t e);
    drive(s);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string nm);
    exp_t e;
    exp_t act;
    @(negedge clk);
    act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           forward_a_e, forward_b_e, ctrl_state, mem_fault};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: no expected entry queued", nm);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("[TB] FAIL %s: got stl=%b fl=%b fa=%b fb=%b st=%b flt=%b, want stl=%b fl=%b fa=%b fb=%b st=%b flt=%b",
                 nm, act.stl, act.fl, act.fa, act.fb, act.st, act.flt,
                 e.stl, e.fl, e.fa, e.fb, e.st, e.flt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t s, input exp_t e, input string nm);
    applyStimulus(s, e);
    checkOutput(nm);
  endtask

  task automatic add(input in_t v, input exp_t e);
    vec_t t;
    t.i = v;
    t.e = e;
    tbl.push_back(t);
  endtask

  initial begin
    in_t v;
    exp_t z;
    z = ex(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    reset = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step('0, z, "reset_state");

    v = '0; add(v, z);
    v = '0; v.rd_e = 5; v.ld_e = 1; v.rt_d = 5; add(v, ex(4'b1100, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
    v = '0; v.rd_e = 7; v.ld_e = 1; v.rs_d = 7; add(v, ex(4'b1100, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
    v = '0; v.rd_e = 0; v.ld_e = 1; add(v, z);
    v = '0; v.rd_e = 5; v.rt_d = 5; add(v, z);
    v = '0; v.rd_m = 3; v.rw_m = 1; v.rd_w = 3; v.rw_w = 1; v.rs_e = 3;
    add(v, ex(4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0));
    v.rd_m = 0; add(v, ex(4'b0000, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
    v.rd_m = 3; v.rs_e = 0; add(v, z);
    v = '0; v.rt_e = 9; v.rd_w = 9; v.rw_w = 1; v.rd_m = 9;
    add(v, ex(4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    v = '0; v.br = 1; add(v, ex(4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
    v = '0; v.br = 1; v.rd_e = 5; v.ld_e = 1; v.rt_d = 5;
    add(v, ex(4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
    v = '0; v.st_m = 1; v.rdy = 1; add(v, z);
    v = '0; v.ld_m = 1; v.rdy = 1; v.rd_e = 4; v.ld_e = 1; v.rs_d = 4;
    add(v, ex(4'b1100, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));

    for (int k = 0; k < tbl.size(); k++) begin
      applyStimulus(tbl[k].i, tbl[k].e);
      checkOutput($sformatf("vec%0d", k));
    end

    // Load-use: one bubble, then the load sits in MEM with no hazard left.
    v = '0; v.rd_e = 5; v.ld_e = 1; v.rt_d = 5;
    step(v, ex(4'b1100, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0), "lu_bubble");
    v = '0; v.rt_d = 5; v.rd_m = 5; v.rw_m = 1; v.ld_m = 1; v.rdy = 1; v.rt_e = 5;
    step(v, ex(4'b0000, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0), "lu_after");
    v = '0; v.rt_e = 5; v.rd_w = 5; v.rw_w = 1;
    step(v, ex(4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0), "lu_wb_fwd");

    // Store waits 3 cycles with a taken branch pending; flush appears only at release.
    v = '0; v.st_m = 1; v.br = 1;
    for (int k = 0; k < 3; k++)
      step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, (k == 0) ? 2'b00 : 2'b01, 1'b0),
           $sformatf("wait%0d", k));
    v.rdy = 1;
    step(v, ex(4'b0000, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0), "wait_release");
    step('0, z, "wait_back_run");

    // Watchdog timeout.
    v = '0; v.ld_m = 1;
    for (int k = 0; k < TB_TIMEOUT; k++)
      step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, (k == 0) ? 2'b00 : 2'b01, 1'b0),
           $sformatf("to_wait%0d", k));
    step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1), "to_fault");
    v = '0; v.rdy = 1; v.br = 1; v.rs_e = 3; v.rd_m = 3; v.rw_m = 1;
    step(v, ex(4'b1111, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1), "fault_sticky");
    reset = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step('0, z, "fault_cleared");

    // Reset during the second MEM_WAIT cycle.
    v = '0; v.st_m = 1;
    step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0), "rmw_run");
    step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0), "rmw_wait1");
    reset = 1'b1;
    step(v, ex(4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0), "rmw_wait2_reset");
    reset = 1'b0;
    step('0, z, "rmw_after");
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({stall_cycles, bubble_count, flush_count} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL perf_reset: got %0d/%0d/%0d, want 0/0/0",
               stall_cycles, bubble_count, flush_count);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
